// File: rtl/instr_register_pkg.sv
// -----------------------------------------------------------------------------
// instr_register_pkg
// Shared types for the instruction register and its read-side engine, plus the
// reference result function. The function is used by the optional result
// checker and by any model that must agree with it.
//   operand_t     : signed 32-bit operand
//   opcode_t      : 4-bit operation code (ZERO..MOD)
//   address_t     : 5-bit register location (32 locations)
//   result_t      : signed 64-bit result
//   instruction_t : packed {opc, op_a, op_b, rez}
// -----------------------------------------------------------------------------
package instr_register_pkg;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;
    typedef logic        [4:0]  address_t;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  rez;
    } instruction_t;

    // Operands are sign-extended to the result width before the operation, so
    // MULT keeps the full product and DIV/MOD cannot overflow.
    // Division by zero is defined to yield 0.
    function automatic result_t calc_result(opcode_t opc, operand_t a, operand_t b);
        result_t ea;
        result_t eb;
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        case (opc)
            ZERO:    return '0;
            PASSA:   return ea;
            PASSB:   return eb;
            ADD:     return ea + eb;
            SUB:     return ea - eb;
            MULT:    return ea * eb;
            DIV:     return (eb == '0) ? '0 : ea / eb;
            MOD:     return (eb == '0) ? '0 : ea % eb;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/instr_result_checker.sv
// -----------------------------------------------------------------------------
// instr_result_checker
// Combinational consistency check of one instruction word: recomputes the
// result from opc/op_a/op_b and flags a difference from the stored rez.
//   instr    in  instruction_t  word to check
//   mismatch out 1              stored rez differs from the recomputed result
// -----------------------------------------------------------------------------
module instr_result_checker
    import instr_register_pkg::*;
(
    input  instruction_t instr,
    output logic         mismatch
);

    always_comb begin
        mismatch = (calc_result(instr.opc, instr.op_a, instr.op_b) != instr.rez);
    end

endmodule

// File: rtl/instr_register_reader.sv
// -----------------------------------------------------------------------------
// instr_register_reader
// Read-side burst engine for the instruction register. A start command walks a
// contiguous range of locations (wrapping modulo DEPTH), captures each word and
// offers it on a valid/ready stream tagged with its address.
// Optional checker: define INSTR_REGISTER_READER_CHECK_EN to flag words whose
// stored rez disagrees with the recomputed result; otherwise out_mismatch = 0.
//   clk, reset_n      clock, asynchronous active-low reset
//   start             begin a burst (sampled only when idle)
//   start_addr, count first location and number of locations (0..DEPTH)
//   busy, done        engine active / one-cycle completion pulse
//   read_pointer      address to the register read port
//   instruction_word  combinational read data for read_pointer
//   out_valid/ready   payload handshake
//   out_addr, out_instr, out_last, out_mismatch  payload
// -----------------------------------------------------------------------------
module instr_register_reader
    import instr_register_pkg::*;
#(
    // Must equal 2**$bits(address_t); address arithmetic wraps naturally.
    parameter int DEPTH = 32
)
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  address_t               start_addr,
    input  logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   done,
    output address_t               read_pointer,
    input  instruction_t           instruction_word,
    output logic                   out_valid,
    input  logic                   out_ready,
    output address_t               out_addr,
    output instruction_t           out_instr,
    output logic                   out_last,
    output logic                   out_mismatch
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] remaining;   // entries not yet fetched

    // NOTE: every variable written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = (count != '0) ? S_FETCH : S_DONE;
            S_FETCH: next_state = S_HOLD;
            S_HOLD:  if (out_ready) next_state = (remaining != '0) ? S_FETCH : S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // read_pointer doubles as the burst address register. It only advances on
    // the way into FETCH, so it already points at the next location during
    // FETCH and holds the last fetched address everywhere else.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            remaining    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            read_pointer <= '0;
            out_valid    <= 1'b0;
            out_addr     <= '0;
            out_instr    <= '0;
            out_last     <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != S_IDLE);
            done  <= (next_state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start && (count != '0)) begin
                        read_pointer <= start_addr;
                        remaining    <= count;
                    end
                end
                S_FETCH: begin
                    out_valid <= 1'b1;
                    out_instr <= instruction_word;
                    out_addr  <= read_pointer;
                    out_last  <= (remaining == ONE);
                    remaining <= remaining - ONE;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (remaining != '0) read_pointer <= address_t'(read_pointer + 1'b1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef INSTR_REGISTER_READER_CHECK_EN
    logic mismatch_now;

    instr_result_checker u_checker (
        .instr    (instruction_word),
        .mismatch (mismatch_now)
    );

    // Captured on the same edge as the payload so it always describes out_instr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               out_mismatch <= 1'b0;
        else if (state == S_FETCH)  out_mismatch <= mismatch_now;
    end
`else
    assign out_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_instr_register_reader.sv
// -----------------------------------------------------------------------------
// tb_instr_register_reader
// Directed bench for instr_register_reader: a table of bursts with
// hand-computed completion cycles and final addresses, plus hand-written
// sequences for back-pressure, asynchronous reset mid-burst and the result
// checker. The instruction register is modelled as a local array.
// -----------------------------------------------------------------------------
module tb_instr_register_reader;
    import instr_register_pkg::*;

    localparam int DEPTH = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    address_t     start_addr;
    logic [5:0]   count;
    logic         busy;
    logic         done;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         out_valid;
    logic         out_ready;
    address_t     out_addr;
    instruction_t out_instr;
    logic         out_last;
    logic         out_mismatch;

    instruction_t mem [DEPTH];
    assign instruction_word = mem[read_pointer];

    instr_register_reader #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .start_addr       (start_addr),
        .count            (count),
        .busy             (busy),
        .done             (done),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_addr         (out_addr),
        .out_instr        (out_instr),
        .out_last         (out_last),
        .out_mismatch     (out_mismatch)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        address_t sa;        // start address
        int       n;         // count
        int       exp_done;  // cycle (relative to start edge T) where done is high
        address_t exp_last;  // read_pointer after the burst (n > 0 only)
        int       pulse;     // cycle to pulse a stray start (0 = none)
    } vec_t;

    // Runs one burst with out_ready held 1. Payload address/data/last are
    // checked as they appear; mm collects out_mismatch per payload.
    task automatic run_burst(input vec_t v, output logic [63:0] mm);
        address_t exp_addr;
        int got;
        int done_at;
        got      = 0;
        done_at  = 0;
        exp_addr = v.sa;
        mm       = '0;
        @(negedge clk);
        start      = 1'b1;
        start_addr = v.sa;
        count      = 6'(v.n);
        out_ready  = 1'b1;
        for (int cyc = 1; cyc <= 200 && done_at == 0; cyc++) begin
            @(negedge clk);
            start = (cyc == v.pulse);
            if (start) begin
                start_addr = 5'd20;
                count      = 6'd5;
            end
            if (cyc == 1) check("busy_first_cycle", busy, 1'b1);
            if (out_valid) begin
                check("payload_addr", out_addr, exp_addr);
                check("payload_instr", out_instr, mem[exp_addr]);
                check("payload_last", out_last, (got == v.n - 1));
                mm[got] = out_mismatch;
                got++;
                exp_addr++;
            end
            if (done) done_at = cyc;
        end
        start = 1'b0;
        check("done_cycle", done_at, v.exp_done);
        check("payload_count", got, v.n);
        @(negedge clk);
        check("busy_after_done", busy, 1'b0);
        check("done_one_cycle", done, 1'b0);
        if (v.n > 0) check("final_read_pointer", read_pointer, v.exp_last);
        @(negedge clk);
        check("stays_idle", busy, 1'b0);
        check("no_stray_valid", out_valid, 1'b0);
    endtask

    vec_t        vecs [7];
    logic [63:0] mm;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++)
            mem[i] = '{opc: ADD, op_a: operand_t'(i), op_b: operand_t'(2 * i), rez: result_t'(3 * i)};

        vecs[0] = '{sa: 5'd0,  n: 3,  exp_done: 7,  exp_last: 5'd2,  pulse: 0};
        vecs[1] = '{sa: 5'd31, n: 3,  exp_done: 7,  exp_last: 5'd1,  pulse: 0};
        vecs[2] = '{sa: 5'd31, n: 2,  exp_done: 5,  exp_last: 5'd0,  pulse: 0};
        vecs[3] = '{sa: 5'd10, n: 1,  exp_done: 3,  exp_last: 5'd10, pulse: 0};
        vecs[4] = '{sa: 5'd7,  n: 0,  exp_done: 1,  exp_last: 5'd0,  pulse: 0};
        vecs[5] = '{sa: 5'd5,  n: 32, exp_done: 65, exp_last: 5'd4,  pulse: 0};
        vecs[6] = '{sa: 5'd0,  n: 2,  exp_done: 5,  exp_last: 5'd1,  pulse: 2};

        // Reset state
        reset_n    = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        out_ready  = 1'b0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_read_pointer", read_pointer, 5'd0);
        check("rst_out_instr", out_instr, 132'd0);
        check("rst_mismatch", out_mismatch, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table of bursts; stored words are self-consistent, so no mismatches
        foreach (vecs[k]) begin
            run_burst(vecs[k], mm);
            check("no_mismatch", mm, 64'd0);
        end

        // Back-pressure: first payload held for 5 cycles
        @(negedge clk);
        start = 1'b1; start_addr = 5'd4; count = 6'd2; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        check("stall_valid", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("stall_addr", out_addr, 5'd4);
            check("stall_instr", out_instr, mem[4]);
            check("stall_read_pointer", read_pointer, 5'd4);
            check("stall_last", out_last, 1'b0);
            @(negedge clk);
        end
        check("stall_still_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        check("release_fetch_valid", out_valid, 1'b0);
        check("release_read_pointer", read_pointer, 5'd5);
        @(negedge clk);
        check("release_addr", out_addr, 5'd5);
        check("release_last", out_last, 1'b1);
        @(negedge clk);
        check("release_done", done, 1'b1);
        @(negedge clk);
        check("release_idle", busy, 1'b0);

        // Asynchronous reset while a payload is held
        start = 1'b1; start_addr = 5'd8; count = 6'd3; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_valid", out_valid, 1'b1);
        check("pre_reset_busy", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_read_pointer", read_pointer, 5'd0);
        check("async_rst_addr", out_addr, 5'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_burst('{sa: 5'd3, n: 2, exp_done: 5, exp_last: 5'd4, pulse: 0}, mm);

        // Result checker words
        mem[12] = '{opc: ADD, op_a: 32'sd7, op_b: -32'sd3, rez: 64'sd4};
        mem[13] = '{opc: ADD, op_a: 32'sd7, op_b: -32'sd3, rez: 64'sd5};
        mem[14] = '{opc: DIV, op_a: 32'sd9, op_b: 32'sd0,  rez: 64'sd0};
        run_burst('{sa: 5'd12, n: 3, exp_done: 7, exp_last: 5'd14, pulse: 0}, mm);
        check("chk_add_good", mm[0], 1'b0);
`ifdef INSTR_REGISTER_READER_CHECK_EN
        check("chk_add_bad", mm[1], 1'b1);
`else
        check("chk_add_bad", mm[1], 1'b0);
`endif
        check("chk_div_zero", mm[2], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_register_reader.md
# instr_register_reader

Sequential read-side engine for the instruction register. On a start command it walks a contiguous, wrapping range of register locations by driving `read_pointer`. It captures each `instruction_word` and presents it downstream on a valid/ready stream tagged with its address. It sits between the instruction register's read port and any consumer (scoreboard, execution stage), replacing ad-hoc per-address reads.

## Interface

Parameters:
- `DEPTH`, default 32: number of register locations. Must equal 2**$bits(address_t). Addresses wrap modulo DEPTH.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a read burst; sampled only in IDLE.
- `start_addr`  in  address_t  first location to read.
- `count`  in  $clog2(DEPTH)+1  number of locations, 0..DEPTH.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when a burst completes.
- `read_pointer`  out  address_t  address driven to the instruction register read port.
- `instruction_word`  in  instruction_t  combinational read data for `read_pointer`.
- `out_valid`  out  1  the `out_*` payload is valid.
- `out_ready`  in  1  consumer accepts the payload.
- `out_addr`  out  address_t  location the payload was read from.
- `out_instr`  out  instruction_t  captured opc, op_a, op_b, rez.
- `out_last`  out  1  payload is the final entry of the burst.
- `out_mismatch`  out  1  stored rez differs from the recomputed result. Present only with the checker macro; tied to 0 without it.

## Operation

- States: IDLE, FETCH, HOLD, DONE.
- IDLE:
  - `start`=1 and `count`>0 → latch `start_addr` and `count` into addr and remaining → FETCH.
  - `start`=1 and `count`=0 → DONE. No payload is emitted.
- FETCH:
  - `read_pointer`=addr.
  - At the clock edge, register `instruction_word` into `out_instr`, addr into `out_addr`, and (remaining==1) into `out_last`.
  - Set `out_valid`, decrement remaining, set addr ← addr+1 modulo DEPTH → HOLD.
- HOLD:
  - `out_valid`=1; payload stays stable while `out_ready`=0.
  - On the edge where `out_valid`&&`out_ready`: clear `out_valid`. Go to FETCH if remaining>0, else DONE.
- DONE: `done`=1 for exactly one cycle → IDLE.
- `start` is ignored in every state except IDLE. It is never queued.
- `read_pointer` holds its last value outside FETCH.
- Wrap-around: `start_addr`=DEPTH-1 with `count`=2 reads DEPTH-1, then 0.
- `count`=DEPTH reads every location exactly once.
- Reset (asynchronous, any state, including mid-burst): state=IDLE, all outputs 0, `read_pointer`=0. Any partially delivered burst is abandoned.

## Timing

- `start` sampled at edge T → FETCH during cycle T+1 with `read_pointer`=`start_addr`.
- `out_valid` is high from cycle T+2.
- Minimum cost is 2 cycles per entry (FETCH + HOLD with `out_ready` already 1).
- N-entry burst with `out_ready` tied 1: `done` in cycle T+2N+1; `busy` low from T+2N+2.
- `busy` is high from T+1 through the DONE cycle inclusive.
- `count`=0: DONE in T+1, IDLE in T+2.
- All outputs are registered. There are no combinational paths from `out_ready` or `instruction_word` to any output. `read_pointer` is a function of state and addr only.

## Configuration

- Macro: `INSTR_REGISTER_READER_CHECK_EN`.
- Defined:
  - In FETCH, recompute the expected result from opc/op_a/op_b, computed in result_t width with operands sign-extended.
  - Rules: ZERO→0, PASSA→a, PASSB→b, ADD→a+b, SUB→a−b, MULT→a*b, DIV→a/b, MOD→a%b. DIV and MOD with b=0 → 0.
  - Register `out_mismatch` = (expected ≠ rez) alongside the payload.
- Undefined: no checker logic is instantiated; `out_mismatch` is constant 0.

## Structure

- `instr_register_pkg` holds operand_t, opcode_t, address_t, result_t and instruction_t, plus a new function `calc_result(opcode_t, operand_t, operand_t)` returning result_t. The design and the bench share this function.
- The reader state enum is local to the module.
- Sub-module `instr_result_checker`: combinational wrapper around `calc_result` plus the compare. Instantiated only under the macro.

## Test plan

- Reset, then `start`, `start_addr`=0, `count`=3, `out_ready`=1, with locations 0..2 preloaded → three payloads with `out_addr` 0, 1, 2. `out_last` is set only on addr 2. `done` in cycle T+7.
- `start_addr`=31, `count`=3 → `out_addr` sequence 31, 0, 1.
- `out_ready` held 0 for 5 cycles on the first payload → `out_instr`/`out_addr` stable and `read_pointer` unchanged. Release → burst completes normally.
- `count`=0 → no `out_valid`; `done` in T+1. A second `start` pulsed mid-burst is ignored.
- Reset asserted asynchronously mid-HOLD → `out_valid`, `busy`, `done` and `read_pointer` go to 0 immediately. A new `start` after release works.
- Checker on:
  - Location holds ADD, a=7, b=−3, rez=4 → `out_mismatch`=0.
  - Location holds ADD, a=7, b=−3, rez=5 → `out_mismatch`=1.
  - Location holds DIV, b=0, rez=0 → `out_mismatch`=0.
